// File: rtl/dds_sweep_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : dds_sweep_scheduler_if
// Description : Command-bus and update-path bundle for the DDS frequency-sweep
//               scheduler.
//               master : command source / update sink (drives cmd_*, sweep_stop)
//               slave  : sweep scheduler (drives cmd_ready, upd_*, status)
// Revision    : 1.0 - initial release
// ============================================================================
interface dds_sweep_scheduler_if;
    // Command bus
    logic [7:0]  cmd_type;
    logic [15:0] cmd_length;
    logic [7:0]  cmd_data;
    logic [15:0] cmd_data_index;
    logic        cmd_start;
    logic        cmd_data_valid;
    logic        cmd_done;
    logic        cmd_ready;
    // Control / update path
    logic        sweep_stop;
    logic        upd_valid;
    logic        upd_channel;
    logic [31:0] upd_freq_word;
    logic [15:0] point_index;
    logic        sweep_busy;
    logic        sweep_done;

    modport master (
        output cmd_type, cmd_length, cmd_data, cmd_data_index,
               cmd_start, cmd_data_valid, cmd_done, sweep_stop,
        input  cmd_ready, upd_valid, upd_channel, upd_freq_word,
               point_index, sweep_busy, sweep_done
    );

    modport slave (
        input  cmd_type, cmd_length, cmd_data, cmd_data_index,
               cmd_start, cmd_data_valid, cmd_done, sweep_stop,
        output cmd_ready, upd_valid, upd_channel, upd_freq_word,
               point_index, sweep_busy, sweep_done
    );
endinterface
`default_nettype wire

// File: rtl/dds_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dds_sweep_scheduler
// Description : Frequency-sweep sequencer for the dual-channel DDS. Receives a
//               15-byte sweep command, then steps a frequency word from S by P
//               over N+1 points, holding each point D_eff clock cycles and
//               emitting a one-cycle update strobe at every point change.
// Ports       : clk  - system clock (rising edge)
//               rst  - synchronous active-high reset
//               bus  - dds_sweep_scheduler_if.slave (command bus, sweep_stop,
//                      update strobe/word/channel, point_index, busy, done)
// Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_scheduler #(
    parameter logic [7:0] CMD_TYPE_SWEEP = 8'hFE
) (
    input  wire logic             clk,
    input  wire logic             rst,
    dds_sweep_scheduler_if.slave  bus
);

    localparam int c_PAYLOAD_BYTES = 15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_ARM   = 2'd2,
        S_SWEEP = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_buf [c_PAYLOAD_BYTES];

    // Parameters latched in ARM
    logic        r_repeat;
    logic [31:0] r_start;
    logic [31:0] r_step;
    logic [15:0] r_n;
    logic [31:0] r_dwell_m1;

    // Working state
    logic [31:0] r_word;
    logic [15:0] r_index;
    logic [31:0] r_cnt;

    // Registered outputs
    logic        r_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_upd_valid;
    logic        r_upd_channel;
    logic [31:0] r_upd_word;

    // Field decode straight from the payload buffer (big-endian)
    logic        w_channel;
    logic        w_repeat;
    logic [31:0] w_start;
    logic [31:0] w_step;
    logic [15:0] w_n;
    logic [31:0] w_dwell;
    logic [31:0] w_dwell_m1;
    logic        w_byte_ok;
    logic        w_end_point;
    logic [31:0] w_next_word;

    assign w_channel   = r_buf[0][0];
    assign w_repeat    = r_buf[0][1];
    assign w_start     = {r_buf[1],  r_buf[2],  r_buf[3],  r_buf[4]};
    assign w_step      = {r_buf[5],  r_buf[6],  r_buf[7],  r_buf[8]};
    assign w_n         = {r_buf[9],  r_buf[10]};
    assign w_dwell     = {r_buf[11], r_buf[12], r_buf[13], r_buf[14]};
    // D=0 behaves as D=1, so the reload value is D_eff-1 in both cases
    assign w_dwell_m1  = (w_dwell == 32'd0) ? 32'd0 : (w_dwell - 32'd1);
    assign w_byte_ok   = (bus.cmd_data_index < 16'(c_PAYLOAD_BYTES));
    assign w_end_point = (r_cnt == 32'd0);
    assign w_next_word = r_word + r_step;

    // cmd_length is informational only
    logic w_unused;
    assign w_unused = ^bus.cmd_length;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            for (int i = 0; i < c_PAYLOAD_BYTES; i++) r_buf[i] <= 8'd0;
            r_repeat      <= 1'b0;
            r_start       <= 32'd0;
            r_step        <= 32'd0;
            r_n           <= 16'd0;
            r_dwell_m1    <= 32'd0;
            r_word        <= 32'd0;
            r_index       <= 16'd0;
            r_cnt         <= 32'd0;
            r_ready       <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_upd_valid   <= 1'b0;
            r_upd_channel <= 1'b0;
            r_upd_word    <= 32'd0;
        end else begin
            r_upd_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_start && (bus.cmd_type == CMD_TYPE_SWEEP)) begin
                        // Start from a zeroed buffer so short payloads read as 0
                        for (int i = 0; i < c_PAYLOAD_BYTES; i++) r_buf[i] <= 8'd0;
                        r_state <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (bus.cmd_data_valid && w_byte_ok)
                        r_buf[bus.cmd_data_index[3:0]] <= bus.cmd_data;
                    if (bus.cmd_done) begin
                        r_state <= S_ARM;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARM: begin
                    r_repeat   <= w_repeat;
                    r_start    <= w_start;
                    r_step     <= w_step;
                    r_n        <= w_n;
                    r_dwell_m1 <= w_dwell_m1;
                    if (bus.sweep_stop) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        // Output word/channel change only together with a strobe
                        r_state       <= S_SWEEP;
                        r_word        <= w_start;
                        r_index       <= 16'd0;
                        r_cnt         <= w_dwell_m1;
                        r_upd_valid   <= 1'b1;
                        r_upd_word    <= w_start;
                        r_upd_channel <= w_channel;
                    end
                end
                S_SWEEP: begin
                    if (bus.sweep_stop) begin
                        // Stop also swallows a strobe that end-of-point would schedule
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (!w_end_point) begin
                        r_cnt <= r_cnt - 32'd1;
                    end else if (r_index < r_n) begin
                        r_word      <= w_next_word;
                        r_index     <= r_index + 16'd1;
                        r_cnt       <= r_dwell_m1;
                        r_upd_valid <= 1'b1;
                        r_upd_word  <= w_next_word;
                    end else if (r_repeat) begin
                        r_word      <= r_start;
                        r_index     <= 16'd0;
                        r_cnt       <= r_dwell_m1;
                        r_upd_valid <= 1'b1;
                        r_upd_word  <= r_start;
                    end else begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready     = r_ready;
    assign bus.sweep_busy    = r_busy;
    assign bus.sweep_done    = r_done;
    assign bus.upd_valid     = r_upd_valid;
    assign bus.upd_channel   = r_upd_channel;
    assign bus.upd_freq_word = r_upd_word;
    assign bus.point_index   = r_index;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_sweep_scheduler
// Description : Scoreboard bench for dds_sweep_scheduler. The driver decodes
//               each payload with a sweep-level reference model and queues the
//               expected strobes, done pulses and status snapshots; a monitor
//               on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_sweep_scheduler;

    typedef struct packed {
        logic [31:0] cyc;
        logic        ch;
        logic [31:0] word;
        logic [15:0] idx;
    } strobe_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        full;   // all outputs at reset values
        logic        ready;
        logic        busy;
    } stat_t;

    typedef logic [7:0] pl_t [15];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dds_sweep_scheduler_if bus ();

    dds_sweep_scheduler #(.CMD_TYPE_SWEEP(8'hFE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    strobe_t     exp_q  [$];
    int unsigned done_q [$];
    stat_t       chk_q  [$];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors    = 0;
    int miscompares = 0;
    bit tb_end     = 1'b0;

    strobe_t     m_e, m_a;
    stat_t       m_s;
    int unsigned m_d;
    logic        m_ok;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (bus.upd_valid === 1'b1) begin
            vectors++;
            m_a = '{cyc, bus.upd_channel, bus.upd_freq_word, bus.point_index};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL strobe: unexpected upd_valid cyc=%0d ch=%0b word=%h idx=%0d, required none",
                         cyc, bus.upd_channel, bus.upd_freq_word, bus.point_index);
            end else begin
                m_e = exp_q.pop_front();
                if (m_a !== m_e) begin
                    miscompares++;
                    $display("FAIL strobe: got cyc=%0d ch=%0b word=%h idx=%0d, required cyc=%0d ch=%0b word=%h idx=%0d",
                             m_a.cyc, m_a.ch, m_a.word, m_a.idx, m_e.cyc, m_e.ch, m_e.word, m_e.idx);
                end
            end
        end
        if (bus.sweep_done === 1'b1) begin
            vectors++;
            if (done_q.size() == 0) begin
                miscompares++;
                $display("FAIL done: unexpected sweep_done at cyc=%0d, required none", cyc);
            end else begin
                m_d = done_q.pop_front();
                if (m_d != cyc) begin
                    miscompares++;
                    $display("FAIL done: got cyc=%0d, required cyc=%0d", cyc, m_d);
                end
            end
        end
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            m_s = chk_q.pop_front();
            vectors++;
            if (m_s.full)
                m_ok = (bus.cmd_ready === 1'b1) &&
                       ({bus.upd_valid, bus.upd_channel, bus.upd_freq_word,
                         bus.point_index, bus.sweep_busy, bus.sweep_done} === '0);
            else
                m_ok = (bus.cmd_ready === m_s.ready) && (bus.sweep_busy === m_s.busy);
            if (!m_ok) begin
                miscompares++;
                $display("FAIL status(full=%0b) cyc=%0d: got ready=%0b busy=%0b valid=%0b ch=%0b word=%h idx=%0d done=%0b, required ready=%0b busy=%0b",
                         m_s.full, cyc, bus.cmd_ready, bus.sweep_busy, bus.upd_valid, bus.upd_channel,
                         bus.upd_freq_word, bus.point_index, bus.sweep_done, m_s.ready, m_s.busy);
            end
        end
        if (tb_end) begin
            vectors++;
            if (exp_q.size() != 0 || done_q.size() != 0 || chk_q.size() != 0) begin
                miscompares++;
                $display("FAIL leftover: got %0d strobes %0d dones %0d checks pending, required 0",
                         exp_q.size(), done_q.size(), chk_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic make_pl(input logic ch, input logic rep, input logic [31:0] s,
                           input logic [31:0] p, input logic [15:0] n,
                           input logic [31:0] d, output pl_t pl);
        pl[0] = {6'd0, rep, ch};
        pl[1] = s[31:24]; pl[2]  = s[23:16]; pl[3]  = s[15:8]; pl[4]  = s[7:0];
        pl[5] = p[31:24]; pl[6]  = p[23:16]; pl[7]  = p[15:8]; pl[8]  = p[7:0];
        pl[9] = n[15:8];  pl[10] = n[7:0];
        pl[11] = d[31:24]; pl[12] = d[23:16]; pl[13] = d[15:8]; pl[14] = d[7:0];
    endtask

    // cut < 0: run to completion; otherwise stop (or reset) is applied in the
    // cycle first_strobe + cut.
    task automatic send(input logic [7:0] typ, input int nbytes, input pl_t pl,
                        input int cut, input bit use_rst, input bit noisy_stop);
        pl_t         b;
        int unsigned t, first, cutoff, deff, np, dc, target;
        logic        ch, rep;
        logic [31:0] s, p, d;
        logic [15:0] n;

        @(negedge clk);
        bus.cmd_start  = 1'b1;
        bus.cmd_type   = typ;
        bus.cmd_length = 16'(nbytes);
        @(negedge clk);
        bus.cmd_start  = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            bus.cmd_data_valid = 1'b1;
            bus.cmd_data_index = 16'(i);
            bus.cmd_data       = pl[i];
            bus.sweep_stop     = noisy_stop ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        if (nbytes == 15) begin
            // trailing bytes past the payload must be dropped
            for (int j = 15; j < 17; j++) begin
                bus.cmd_data_valid = 1'b1;
                bus.cmd_data_index = 16'(j);
                bus.cmd_data       = 8'($urandom);
                @(negedge clk);
            end
        end
        bus.cmd_data_valid = 1'b0;
        bus.sweep_stop     = 1'b0;
        bus.cmd_done       = 1'b1;
        t = cyc;

        if (typ != 8'hFE) begin
            chk_q.push_back('{t + 1, 1'b0, 1'b1, 1'b0});
            chk_q.push_back('{t + 3, 1'b0, 1'b1, 1'b0});
            @(negedge clk);
            bus.cmd_done = 1'b0;
            repeat (4) @(negedge clk);
            return;
        end

        // reference model: decode the payload as the sweep definition
        for (int i = 0; i < 15; i++) b[i] = (i < nbytes) ? pl[i] : 8'h00;
        ch   = b[0][0];
        rep  = b[0][1];
        s    = {b[1], b[2], b[3], b[4]};
        p    = {b[5], b[6], b[7], b[8]};
        n    = {b[9], b[10]};
        d    = {b[11], b[12], b[13], b[14]};
        deff = (d == 0) ? 1 : d;
        np   = int'(n) + 1;
        first  = t + 2;
        cutoff = (cut < 0) ? 32'hFFFF_FFFF : first + cut;

        chk_q.push_back('{t + 1, 1'b0, 1'b0, 1'b1});
        for (int unsigned k = 0; ; k++) begin
            int unsigned c, pt;
            c  = first + k * deff;
            if (c > cutoff || (!rep && k >= np)) break;
            pt = k % np;
            exp_q.push_back('{c, ch, s + p * pt, 16'(pt)});
        end
        dc = first + np * deff;
        if (!rep && dc <= cutoff) begin
            done_q.push_back(dc);
            chk_q.push_back('{dc, 1'b0, 1'b1, 1'b0});
            chk_q.push_back('{dc + 1, 1'b0, 1'b1, 1'b0});
        end

        @(negedge clk);
        bus.cmd_done = 1'b0;
        if (cut >= 0) begin
            chk_q.push_back('{cutoff + 1, use_rst, 1'b1, 1'b0});
            target = cutoff;
        end else begin
            target = dc + 2;
        end
        while (cyc < target) @(negedge clk);
        if (cut >= 0) begin
            if (use_rst) rst = 1'b1; else bus.sweep_stop = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            bus.sweep_stop = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        pl_t pl;
        bus.cmd_type = 8'h00; bus.cmd_length = 16'h0; bus.cmd_data = 8'h00;
        bus.cmd_data_index = 16'h0; bus.cmd_start = 1'b0; bus.cmd_data_valid = 1'b0;
        bus.cmd_done = 1'b0; bus.sweep_stop = 1'b0;

        @(negedge clk);
        chk_q.push_back('{cyc + 2, 1'b1, 1'b1, 1'b0});
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed: one-shot, channel A
        make_pl(1'b0, 1'b0, 32'h0147AE14, 32'h00010000, 16'd3, 32'd4, pl);
        send(8'hFE, 15, pl, -1, 1'b0, 1'b0);
        // N=0, D=0, channel B
        make_pl(1'b1, 1'b0, 32'h12345678, 32'h11111111, 16'd0, 32'd0, pl);
        send(8'hFE, 15, pl, -1, 1'b0, 1'b0);
        // word wrap-around
        make_pl(1'b0, 1'b0, 32'hFFFFFFF0, 32'h00000020, 16'd1, 32'd2, pl);
        send(8'hFE, 15, pl, -1, 1'b0, 1'b0);
        // repeat mode, stop coinciding with end-of-point after the 5th strobe
        make_pl(1'b1, 1'b1, 32'hA0000000, 32'h00000100, 16'd2, 32'd3, pl);
        send(8'hFE, 15, pl, 14, 1'b0, 1'b0);
        // short payload after a full one: N and D fall back to zero
        make_pl(1'b0, 1'b0, 32'hCAFEBABE, 32'h00000001, 16'h0105, 32'd7, pl);
        send(8'hFE, 9, pl, -1, 1'b0, 1'b0);
        // foreign command type is ignored
        make_pl(1'b0, 1'b0, 32'h1, 32'h1, 16'd1, 32'd1, pl);
        send(8'hFD, 15, pl, -1, 1'b0, 1'b0);
        // reset mid-dwell, then a normal command
        make_pl(1'b1, 1'b0, 32'h55555555, 32'h01000000, 16'd3, 32'd10, pl);
        send(8'hFE, 15, pl, 3, 1'b1, 1'b0);
        make_pl(1'b1, 1'b0, 32'h00000100, 32'h00000010, 16'd2, 32'd2, pl);
        send(8'hFE, 15, pl, -1, 1'b0, 1'b0);

        // Randomized sweeps
        for (int it = 0; it < 12; it++) begin
            logic        ch, rep;
            logic [15:0] n;
            logic [31:0] d;
            int          cut, dm;
            ch  = 1'($urandom_range(0, 1));
            rep = 1'($urandom_range(0, 1));
            n   = 16'($urandom_range(0, 4));
            d   = 32'($urandom_range(0, 5));
            make_pl(ch, rep, $urandom, $urandom, n, d, pl);
            dm  = (d == 0) ? 1 : int'(d);
            if (rep || $urandom_range(0, 3) == 0)
                cut = $urandom_range(0, (int'(n) + 1) * dm * 2);
            else
                cut = -1;
            send(8'hFE, 15, pl, cut, 1'b0, 1'b1);
        end

        repeat (2) @(negedge clk);
        tb_end = 1'b1;
    end

endmodule
`default_nettype wire
